timer_device: RTL and testbench

- Bus responder for one memory-mapped timer slot (Timer0 at 0x7f00–0x7f0b, Timer1 at 0x7f10–0x7f1b). The bridge instantiates it twice.
- Serves the word accesses that the M-stage address/exception check has already admitted. Implements CTRL, PRESET and a read-only COUNT register.
- Runs a 4-state down-counter FSM and raises an interrupt request to the CP0 interrupt inputs.

---
 rtl/timer_device.sv | 140 ++++++++++++++
 tb/tb_timer_device.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_device.sv
// timer_device: responder for one memory-mapped timer slot.
// Word 0 CTRL {IM, MODE[1:0], EN}, word 1 PRESET, word 2 COUNT (read-only),
// word 3 status when TIMER_STATUS_EN is defined, otherwise zero.
// Optional build macro: TIMER_STATUS_EN.
module timer_device #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic [3:0]  ctrl;
    logic [3:0]  ctrlNext;
    logic [31:0] preset;
    logic [31:0] presetNext;
    logic [31:0] count;
    logic [31:0] countNext;
    logic        irqFlag;
    logic        irqFlagNext;

    // Only the word offset is decoded; the bridge selects the slot.
    logic        unusedAddrBits;
    assign unusedAddrBits = ^addr[29:2];

    logic        ctrlWrite;
    logic        presetWrite;
    logic        autoReload;
    assign ctrlWrite   = we && (addr[1:0] == 2'd0);
    assign presetWrite = we && (addr[1:0] == 2'd1);
    // MODE 1x behaves as one-shot, so only 01 reloads.
    assign autoReload  = (ctrl[2:1] == 2'b01);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and register updates; CPU writes are applied last so they win.
    always_comb begin
        stateNext   = state;
        ctrlNext    = ctrl;
        presetNext  = preset;
        countNext   = count;
        irqFlagNext = irqFlag;
        case (state)
            IDLE: begin
                if (ctrl[0]) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                countNext = preset;
                stateNext = CNT;
            end
            CNT: begin
                if (!ctrl[0]) begin
                    stateNext = IDLE;
                end else if (count > 32'd1) begin
                    countNext = count - 32'd1;
                end else begin
                    countNext   = 32'd0;
                    irqFlagNext = 1'b1;
                    stateNext   = INT;
                end
            end
            INT: begin
                stateNext = IDLE;
                if (autoReload) begin
                    irqFlagNext = 1'b0;
                end else begin
                    ctrlNext[0] = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        // A CTRL write doubles as the software acknowledge of the interrupt.
        if (ctrlWrite) begin
            ctrlNext    = din[3:0];
            irqFlagNext = 1'b0;
        end
        if (presetWrite) begin
            presetNext = din;
        end
    end

    // Architectural registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl    <= 4'd0;
            preset  <= PRESET_RST;
            count   <= 32'd0;
            irqFlag <= 1'b0;
        end else begin
            ctrl    <= ctrlNext;
            preset  <= presetNext;
            count   <= countNext;
            irqFlag <= irqFlagNext;
        end
    end

    // Read mux, purely combinational with no side effects.
    always_comb begin
        dout = 32'd0;
        case (addr[1:0])
            2'd0: dout = {28'd0, ctrl};
            2'd1: dout = preset;
            2'd2: dout = count;
            default: begin
`ifdef TIMER_STATUS_EN
                dout = {27'd0, irqFlag, state, 2'b00};
`else
                dout = 32'd0;
`endif
            end
        endcase
    end

    assign irq = ctrl[3] & irqFlag;

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: one-shot, auto-reload, write collisions,
// preset/count write behaviour, EN drop during LOAD and asynchronous reset.
module tb_timer_device;

    logic        clk;
    logic        reset;
    logic [29:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int errors = 0;
    int checks = 0;

    localparam logic [29:0] BASE = 30'h1fc0;

    timer_device #(.PRESET_RST(32'h0000_0000)) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        addr = BASE + {28'd0, off};
        din  = data;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] off, input logic [31:0] exp);
        addr = BASE + {28'd0, off};
        #1;
        chk(tag, dout, exp);
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        din   = 32'd0;
        addr  = BASE;
        tick();
        tick();
        rd("rst_ctrl", 2'd0, 32'd0);
        rd("rst_preset", 2'd1, 32'd0);
        rd("rst_count", 2'd2, 32'd0);
        rd("rst_word3", 2'd3, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        tick();

        // One-shot PRESET=5 with IM: fires at E0+7.
        wr(2'd1, 32'd5);
        rd("os_preset", 2'd1, 32'd5);
        wr(2'd0, 32'h9);
        tick();
        tick();
        for (int k = 5; k >= 1; k--) begin
            rd($sformatf("os_count%0d", k), 2'd2, k);
            chk("os_irq_low", {31'd0, irq}, 32'd0);
            tick();
        end
        chk("os_irq_fire", {31'd0, irq}, 32'd1);
        rd("os_count_zero", 2'd2, 32'd0);
        rd("os_ctrl_in_int", 2'd0, 32'h9);
        tick();
        rd("os_ctrl_after", 2'd0, 32'h8);
        chk("os_irq_hold1", {31'd0, irq}, 32'd1);
        tick();
        tick();
        chk("os_irq_hold2", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'd0);
        chk("os_irq_ack", {31'd0, irq}, 32'd0);
        rd("os_ctrl_ack", 2'd0, 32'd0);

        // Auto-reload PRESET=3: irq one cycle in six, first after E0+5.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hb);
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk($sformatf("ar_irq_e%0d", k), {31'd0, irq},
                {31'd0, (k >= 5) && (((k - 5) % 6) == 0)});
        end
        wr(2'd0, 32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("ar_stopped", {31'd0, irq}, 32'd0);
            tick();
        end

        // COUNT write ignored, PRESET write mid-count only affects next reload.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd("cw_count10", 2'd2, 32'd10);
        tick();
        wr(2'd2, 32'hdead_beef);
        rd("cw_count8", 2'd2, 32'd8);
        wr(2'd1, 32'd2);
        rd("cw_count7", 2'd2, 32'd7);
        rd("cw_preset2", 2'd1, 32'd2);
        for (int k = 0; k < 6; k++) tick();
        rd("cw_count1", 2'd2, 32'd1);
        tick();
        rd("cw_count_end", 2'd2, 32'd0);
        chk("cw_irq_masked", {31'd0, irq}, 32'd0);
        tick();
        rd("cw_en_cleared", 2'd0, 32'h0);
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd("cw_reload2", 2'd2, 32'd2);
        tick();
        tick();
        chk("im0_irq", {31'd0, irq}, 32'd0);
`ifdef TIMER_STATUS_EN
        rd("im0_status_int", 2'd3, 32'h1c);
`else
        rd("im0_word3", 2'd3, 32'h0);
`endif
        tick();
`ifdef TIMER_STATUS_EN
        rd("im0_status_idle", 2'd3, 32'h10);
`endif
        wr(2'd0, 32'h8);
        chk("im0_irq_after_ack", {31'd0, irq}, 32'd0);
`ifdef TIMER_STATUS_EN
        rd("im0_status_ack", 2'd3, 32'h0);
`endif
        rd("im0_ctrl", 2'd0, 32'h8);

        // PRESET=0 behaves like 1: fires at E0+3.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        tick();
        chk("p0_irq_e2", {31'd0, irq}, 32'd0);
        tick();
        chk("p0_irq_e3", {31'd0, irq}, 32'd1);

        // CTRL write during INT wins over the FSM clearing EN.
        wr(2'd0, 32'hc);
        rd("int_wr_ctrl_c", 2'd0, 32'hc);
        chk("int_wr_irq_c", {31'd0, irq}, 32'd0);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick();
        tick();
        tick();
        chk("int2_irq", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h9);
        rd("int_wr_ctrl_9", 2'd0, 32'h9);
        chk("int_wr_irq_9", {31'd0, irq}, 32'd0);
        wr(2'd0, 32'h0);

        // CTRL write on the same edge the flag would be set.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        tick();
        tick();
        tick();
        rd("set_clash_count1", 2'd2, 32'd1);
        wr(2'd0, 32'h9);
        rd("set_clash_ctrl", 2'd0, 32'h9);
        chk("set_clash_irq", {31'd0, irq}, 32'd0);
        tick();
        rd("set_clash_ctrl_int", 2'd0, 32'h8);
        chk("set_clash_irq2", {31'd0, irq}, 32'd0);

        // EN cleared during LOAD: LOAD completes, CNT exits with COUNT frozen.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        tick();
        wr(2'd0, 32'h0);
        rd("load_drop_count", 2'd2, 32'd4);
        tick();
        rd("load_drop_frozen1", 2'd2, 32'd4);
        tick();
        rd("load_drop_frozen2", 2'd2, 32'd4);

        // Asynchronous reset while irq is high.
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick();
        tick();
        tick();
        chk("arst_irq_before", {31'd0, irq}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_irq_now", {31'd0, irq}, 32'd0);
        #1 reset = 1'b0;
        tick();

        // Reset mid-CNT at COUNT=57.
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 45; k++) tick();
        rd("mid_count57", 2'd2, 32'd57);
        #1 reset = 1'b1;
        rd("mid_count_rst", 2'd2, 32'd0);
        chk("mid_irq_rst", {31'd0, irq}, 32'd0);
        #1 reset = 1'b0;
        tick();
        tick();
        rd("mid_ctrl_after", 2'd0, 32'd0);
        rd("mid_preset_after", 2'd1, 32'd0);
        rd("mid_count_after", 2'd2, 32'd0);
`ifdef TIMER_STATUS_EN
        rd("mid_status_after", 2'd3, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
